// File: rtl/gate_list_exec_sm_if.sv
// Port bundle for the gate control list executor: time/cycle inputs, GCL
// configuration and admin gates from the controller, operational gates back.
interface gate_list_exec_sm_if #(
  parameter int NUM_QUEUES = 8,
  parameter int ADDR_W     = 4,
  parameter int INTERVAL_W = 32
);
  logic [63:0]             sync_time_ptp_ns_mini;
  logic                    CycleStart;
  logic                    cfg_wr_en;
  logic [ADDR_W-1:0]       cfg_wr_addr;
  logic [NUM_QUEUES-1:0]   cfg_wr_gates;
  logic [INTERVAL_W-1:0]   cfg_wr_interval;
  logic [ADDR_W:0]         cfg_list_len;
  logic [NUM_QUEUES-1:0]   admin_gate_states;
  logic [NUM_QUEUES-1:0]   gate_states;
  logic                    list_active;
  logic [ADDR_W-1:0]       entry_index;
  logic                    entry_change;

  modport master (
    output sync_time_ptp_ns_mini, CycleStart,
    output cfg_wr_en, cfg_wr_addr, cfg_wr_gates, cfg_wr_interval,
    output cfg_list_len, admin_gate_states,
    input  gate_states, list_active, entry_index, entry_change
  );

  modport slave (
    input  sync_time_ptp_ns_mini, CycleStart,
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_gates, cfg_wr_interval,
    input  cfg_list_len, admin_gate_states,
    output gate_states, list_active, entry_index, entry_change
  );
endinterface

// File: rtl/gate_list_exec_sm.sv
// List Execute state machine: restarts the gate control list on every cycle
// timer pulse and steps through its entries against PTP nanosecond time.
module gate_list_exec_sm #(
  parameter int NUM_QUEUES = 8,
  parameter int GCL_DEPTH  = 16,
  parameter int ADDR_W     = 4,
  parameter int INTERVAL_W = 32
) (
  input logic                clk,
  input logic                rst_n,
  gate_list_exec_sm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    APPLY,
    DELAY,
    END_CYCLE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(GCL_DEPTH);

  logic [NUM_QUEUES-1:0] gcl_gates    [GCL_DEPTH];
  logic [INTERVAL_W-1:0] gcl_interval [GCL_DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]     cur_idx_q, cur_idx_d;
  logic [63:0]           base_q, base_d;
  logic [63:0]           exit_q, exit_d;
  logic [NUM_QUEUES-1:0] gates_q, gates_d;
  logic                  change_q, change_d;

  logic [ADDR_W:0]       eff_len;
  logic [ADDR_W:0]       idx_plus1;
  logic [63:0]           entry_exit;
  logic                  exit_hit;

  // Storage is not reset; an entry is only sampled in its APPLY cycle.
  always_ff @(posedge clk) begin
    if (bus.cfg_wr_en) begin
      gcl_gates[bus.cfg_wr_addr]    <= bus.cfg_wr_gates;
      gcl_interval[bus.cfg_wr_addr] <= bus.cfg_wr_interval;
    end
  end

  assign eff_len    = (bus.cfg_list_len > DEPTH_LEN) ? DEPTH_LEN : bus.cfg_list_len;
  assign idx_plus1  = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign entry_exit = base_q + 64'(gcl_interval[idx_q]);
  assign exit_hit   = (bus.sync_time_ptp_ns_mini >= exit_q);

  // A cycle start overrides everything else; leaving IDLE captures the admin
  // gates so the output holds steady until the first entry is applied.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_idx_d = cur_idx_q;
    base_d    = base_q;
    exit_d    = exit_q;
    gates_d   = gates_q;
    change_d  = 1'b0;

    if (bus.CycleStart) begin
      if (bus.cfg_list_len == '0) begin
        state_d   = IDLE;
        idx_d     = '0;
        cur_idx_d = '0;
      end else begin
        if (state_q == IDLE) begin
          gates_d = bus.admin_gate_states;
        end
        state_d = READ;
        base_d  = bus.sync_time_ptp_ns_mini;
        idx_d   = '0;
      end
    end else begin
      unique case (state_q)
        READ: begin
          state_d = APPLY;
        end
        APPLY: begin
          gates_d   = gcl_gates[idx_q];
          cur_idx_d = idx_q;
          change_d  = 1'b1;
          exit_d    = entry_exit;
          base_d    = entry_exit;
          state_d   = DELAY;
        end
        DELAY: begin
          if (exit_hit) begin
            if (idx_plus1 == eff_len) begin
              state_d = END_CYCLE;
            end else begin
              idx_d   = idx_plus1[ADDR_W-1:0];
              state_d = READ;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cur_idx_q <= '0;
      base_q    <= '0;
      exit_q    <= '0;
      gates_q   <= '0;
      change_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_idx_q <= cur_idx_d;
      base_q    <= base_d;
      exit_q    <= exit_d;
      gates_q   <= gates_d;
      change_q  <= change_d;
    end
  end

  assign bus.gate_states  = (state_q == IDLE) ? bus.admin_gate_states : gates_q;
  assign bus.list_active  = (state_q != IDLE);
  assign bus.entry_index  = cur_idx_q;
  assign bus.entry_change = change_q;

endmodule

// File: tb/tb_gate_list_exec_sm.sv
// Randomized and directed bench for gate_list_exec_sm, checked every cycle
// against a timing-level model of list execution.
module tb_gate_list_exec_sm;

  localparam int NQ    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int tests_run     = 0;
  int tests_failed  = 0;
  int time_step     = 1;
  int change_pulses = 0;

  always #5 clk = ~clk;

  gate_list_exec_sm_if #(.NUM_QUEUES(NQ), .ADDR_W(AW), .INTERVAL_W(IW)) bus ();

  gate_list_exec_sm #(
    .NUM_QUEUES(NQ),
    .GCL_DEPTH (DEPTH),
    .ADDR_W    (AW),
    .INTERVAL_W(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: a load happens two cycles after a restart or after the
  // exit time is reached; each load extends the cumulative exit time.
  logic [7:0]  m_gcl_g [DEPTH];
  logic [31:0] m_gcl_i [DEPTH];
  bit          m_run;
  bit          m_wait;
  bit          m_change;
  int          m_cd;
  int          m_k;
  int          m_applied;
  int          m_eff;
  logic [63:0] m_base;
  logic [63:0] m_exit;
  logic [7:0]  m_gates;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_wait = 0; m_change = 0; m_cd = 0; m_k = 0; m_applied = 0;
      m_base = '0; m_exit = '0; m_gates = '0;
    end else begin
      m_eff    = (bus.cfg_list_len > 5'd16) ? 16 : int'(bus.cfg_list_len);
      m_change = 0;
      if (bus.CycleStart) begin
        if (bus.cfg_list_len == 5'd0) begin
          m_run = 0; m_applied = 0; m_cd = 0; m_wait = 0;
        end else begin
          if (!m_run) m_gates = bus.admin_gate_states;
          m_run = 1; m_base = bus.sync_time_ptp_ns_mini; m_k = 0; m_cd = 2; m_wait = 0;
        end
      end else if (m_run) begin
        if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 0) begin
            m_gates   = m_gcl_g[m_k];
            m_applied = m_k;
            m_change  = 1;
            m_exit    = m_base + 64'(m_gcl_i[m_k]);
            m_base    = m_exit;
            m_wait    = 1;
          end
        end else if (m_wait && (bus.sync_time_ptp_ns_mini >= m_exit)) begin
          m_wait = 0;
          if (m_k + 1 != m_eff) begin
            m_k  = (m_k + 1) % DEPTH;
            m_cd = 2;
          end
        end
      end
      if (bus.cfg_wr_en) begin
        m_gcl_g[bus.cfg_wr_addr] = bus.cfg_wr_gates;
        m_gcl_i[bus.cfg_wr_addr] = bus.cfg_wr_interval;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("gate_states", 64'(bus.gate_states), 64'(m_run ? m_gates : bus.admin_gate_states));
      checkOutput("list_active", 64'(bus.list_active), 64'(m_run));
      checkOutput("entry_index", 64'(bus.entry_index), 64'(m_applied));
      checkOutput("entry_change", 64'(bus.entry_change), 64'(m_change));
      if (bus.entry_change) change_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.CycleStart = 1'b0;
    bus.cfg_wr_en  = 1'b0;
    bus.sync_time_ptp_ns_mini = bus.sync_time_ptp_ns_mini + 64'(time_step);
  endtask

  task automatic applyStimulus(input bit cs);
    bus.CycleStart = cs;
    tick();
  endtask

  task automatic writeEntry(input int addr, input logic [7:0] g, input logic [31:0] iv);
    bus.cfg_wr_en       = 1'b1;
    bus.cfg_wr_addr     = AW'(addr);
    bus.cfg_wr_gates    = g;
    bus.cfg_wr_interval = iv;
    tick();
  endtask

  task automatic runUntil(input logic [63:0] t);
    int guard = 0;
    while (bus.sync_time_ptp_ns_mini != t && guard < 50000) begin
      tick();
      guard++;
    end
    if (bus.sync_time_ptp_ns_mini != t) checkOutput("runUntil_timeout", bus.sync_time_ptp_ns_mini, t);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.CycleStart = 1'b0;
    bus.cfg_wr_en  = 1'b0;
    bus.sync_time_ptp_ns_mini = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int r;
    bus.sync_time_ptp_ns_mini = '0;
    bus.CycleStart        = 1'b0;
    bus.cfg_wr_en         = 1'b0;
    bus.cfg_wr_addr       = '0;
    bus.cfg_wr_gates      = '0;
    bus.cfg_wr_interval   = '0;
    bus.cfg_list_len      = 5'd2;
    bus.admin_gate_states = 8'h3C;

    doReset();
    @(negedge clk);
    checkOutput("reset_gates_admin", 64'(bus.gate_states), 64'h3C);
    checkOutput("reset_active", 64'(bus.list_active), 64'h0);
    checkOutput("reset_index", 64'(bus.entry_index), 64'h0);

    for (int i = 0; i < DEPTH; i++) writeEntry(i, 8'(i * 17), 32'(i * 10 + 5));
    writeEntry(0, 8'hFF, 32'd1000);
    writeEntry(1, 8'h01, 32'd2000);

    // Basic two-entry list
    bus.sync_time_ptp_ns_mini = '0;
    change_pulses = 0;
    applyStimulus(1'b1);
    runUntil(3);    @(negedge clk);
    checkOutput("s1_gates_t3", 64'(bus.gate_states), 64'hFF);
    checkOutput("s1_change_t3", 64'(bus.entry_change), 64'h1);
    runUntil(1002); @(negedge clk);
    checkOutput("s1_gates_t1002", 64'(bus.gate_states), 64'hFF);
    runUntil(1003); @(negedge clk);
    checkOutput("s1_gates_t1003", 64'(bus.gate_states), 64'h01);
    checkOutput("s1_index_t1003", 64'(bus.entry_index), 64'h1);
    runUntil(3999); @(negedge clk);
    checkOutput("s1_end_gates", 64'(bus.gate_states), 64'h01);
    checkOutput("s1_end_active", 64'(bus.list_active), 64'h1);
    checkOutput("s1_pulses", 64'(change_pulses), 64'd2);

    // Second cycle start restarts at entry 0
    runUntil(4000);
    change_pulses = 0;
    applyStimulus(1'b1);
    runUntil(4002); @(negedge clk);
    checkOutput("s2_gates_t4002", 64'(bus.gate_states), 64'h01);
    runUntil(4003); @(negedge clk);
    checkOutput("s2_gates_t4003", 64'(bus.gate_states), 64'hFF);
    checkOutput("s2_index_t4003", 64'(bus.entry_index), 64'h0);
    runUntil(4010); @(negedge clk);
    checkOutput("s2_pulses", 64'(change_pulses), 64'd1);

    // Overrun: restart during a long entry moves its exit time
    doReset();
    writeEntry(0, 8'h81, 32'd10000);
    writeEntry(1, 8'h18, 32'd100);
    bus.sync_time_ptp_ns_mini = '0;
    applyStimulus(1'b1);
    runUntil(5000);
    change_pulses = 0;
    applyStimulus(1'b1);
    runUntil(5003);  @(negedge clk);
    checkOutput("s3_reapply_change", 64'(bus.entry_change), 64'h1);
    checkOutput("s3_reapply_gates", 64'(bus.gate_states), 64'h81);
    runUntil(10003); @(negedge clk);
    checkOutput("s3_gates_t10003", 64'(bus.gate_states), 64'h81);
    runUntil(15002); @(negedge clk);
    checkOutput("s3_gates_t15002", 64'(bus.gate_states), 64'h81);
    runUntil(15003); @(negedge clk);
    checkOutput("s3_gates_t15003", 64'(bus.gate_states), 64'h18);
    checkOutput("s3_index_t15003", 64'(bus.entry_index), 64'h1);

    // Empty list: cycle starts leave admin gates in force
    bus.admin_gate_states = 8'hA5;
    bus.cfg_list_len      = 5'd0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1);
      @(negedge clk);
      checkOutput("s4_gates", 64'(bus.gate_states), 64'hA5);
      checkOutput("s4_active", 64'(bus.list_active), 64'h0);
      tick();
    end

    // Zero interval entry lasts exactly one wait cycle
    doReset();
    writeEntry(0, 8'h0F, 32'd0);
    writeEntry(1, 8'hF0, 32'd500);
    bus.cfg_list_len          = 5'd2;
    bus.admin_gate_states     = 8'h00;
    bus.sync_time_ptp_ns_mini = 64'd100;
    applyStimulus(1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gate_states == 8'h0F) cnt++;
      tick();
    end
    checkOutput("s5_zero_cycles", 64'(cnt), 64'd3);
    @(negedge clk);
    checkOutput("s5_second_gates", 64'(bus.gate_states), 64'hF0);
    checkOutput("s5_second_index", 64'(bus.entry_index), 64'h1);

    // Asynchronous reset while waiting in an entry
    bus.admin_gate_states = 8'h5A;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_gates", 64'(bus.gate_states), 64'h5A);
    checkOutput("s6_rst_active", 64'(bus.list_active), 64'h0);
    checkOutput("s6_rst_index", 64'(bus.entry_index), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic, including a segment that wraps 64-bit time
    for (int seg = 0; seg < 4; seg++) begin
      time_step = 1 + (seg % 3);
      bus.sync_time_ptp_ns_mini = (seg == 3) ? 64'hFFFF_FFFF_FFFF_FE00 : 64'(seg * 100000);
      bus.cfg_list_len = 5'($urandom_range(1, 20));
      for (int c = 0; c < 4000; c++) begin
        r = $urandom_range(0, 999);
        if (r < 20) begin
          bus.cfg_wr_en       = 1'b1;
          bus.cfg_wr_addr     = AW'($urandom_range(0, DEPTH - 1));
          bus.cfg_wr_gates    = 8'($urandom);
          bus.cfg_wr_interval = 32'($urandom_range(0, 40));
        end
        if (r >= 20 && r < 30) bus.admin_gate_states = 8'($urandom);
        if (r == 500) bus.cfg_list_len = 5'($urandom_range(0, 31));
        if (r == 501) bus.cfg_list_len = 5'($urandom_range(1, 16));
        applyStimulus(r >= 988);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gate_list_exec_sm.md
# gate_list_exec_sm

- Implements the 802.1Q-2018 8.6.9.2 List Execute state machine for the egress port's gate control list (GCL).
- Sits directly downstream of the cycle timer. Each `CycleStart` pulse restarts the list at entry 0. It then steps through the programmed entries, driving the per-queue gate states that the transmission selection logic consumes.
- Entry boundaries are timed against the same PTP nanosecond time the cycle timer uses, so gate changes stay aligned to the cycle grid.

## Interface
Parameters:
- NUM_QUEUES, 8, number of traffic-class gates
- GCL_DEPTH, 16, number of GCL entries (power of two)
- ADDR_W, 4, log2(GCL_DEPTH)
- INTERVAL_W, 32, width of the per-entry time interval in ns

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset; asynchronous assert, active-low
- sync_time_ptp_ns_mini  in  64  current synchronized PTP time, ns
- CycleStart  in  1  one-cycle pulse from the cycle timer
- cfg_wr_en  in  1  GCL entry write strobe
- cfg_wr_addr  in  ADDR_W  entry index to write
- cfg_wr_gates  in  NUM_QUEUES  gate vector for that entry; 1 = open
- cfg_wr_interval  in  INTERVAL_W  entry duration, ns
- cfg_list_len  in  ADDR_W+1  number of valid entries, 0..GCL_DEPTH
- admin_gate_states  in  NUM_QUEUES  gates applied when the list is not running
- gate_states  out  NUM_QUEUES  operational gate vector
- list_active  out  1  high while entries are being executed
- entry_index  out  ADDR_W  index of the entry currently applied
- entry_change  out  1  one-cycle pulse whenever gate_states is loaded from an entry

## Operation
- GCL storage: register array of {gates, interval}.
  - Written on `cfg_wr_en` at posedge clk.
  - An entry is read only when it is loaded.
  - A write to an entry not yet loaded in the current cycle takes effect in the same cycle.
- States:
  - IDLE
  - READ: address presented
  - APPLY: entry applied, exit time computed
  - DELAY: wait for exit time
  - END_CYCLE: list exhausted, hold
- IDLE:
  - `gate_states = admin_gate_states` (follows the input continuously).
  - On `CycleStart` with `cfg_list_len != 0`:
    - latch BaseTime = sync_time_ptp_ns_mini;
    - set idx = 0;
    - go to READ.
- READ: go to APPLY next cycle.
- APPLY:
  - `gate_states <= entry[idx].gates` and `entry_change = 1`;
  - ExitTime = BaseTime + zero-extended interval; BaseTime <= ExitTime;
  - go to DELAY.
- DELAY:
  - when `sync_time_ptp_ns_mini >= ExitTime`:
    - idx+1 == cfg_list_len → END_CYCLE;
    - otherwise idx++ → READ.
- END_CYCLE: hold the last gates. `CycleStart` → BaseTime = time, idx = 0 → READ.
- Cumulative ExitTime (base plus the sum of intervals) prevents drift from per-entry latency.
- Interval 0: the exit condition is already true on the first DELAY cycle, so the entry lasts exactly one DELAY cycle.
- Arithmetic: 64-bit unsigned add, wrap modulo 2^64. The compare is unsigned.
- `cfg_list_len` is sampled at each DELAY exit check. Values above GCL_DEPTH are treated as GCL_DEPTH.
- `list_active` = 1 in READ, APPLY, DELAY and END_CYCLE.

## Timing
- Reset values: state IDLE, `gate_states` = `admin_gate_states` (combinational in IDLE), `list_active` 0, `entry_index` 0, `entry_change` 0, BaseTime/ExitTime 0. GCL contents are not reset.
- Latency:
  - `CycleStart` high in cycle N (state IDLE or END_CYCLE) → READ in N+1 → APPLY in N+2.
  - `gate_states` and `entry_change` update at the end of N+2.
- Entry step: exit detected in DELAY cycle M → new gates registered at the end of M+2.
- CycleStart in READ, APPLY or DELAY (cycle overrun):
  - abandon the current entry;
  - BaseTime = time; idx = 0; go to READ.
  - This has priority over the DELAY exit condition in the same cycle.
- CycleStart while `cfg_list_len == 0`: the block stays in or returns to IDLE, with admin gates applied the next cycle.
- Reset mid-list: immediate return to IDLE; admin gates are visible combinationally while rst_n is low.
- Write to entry idx during its APPLY cycle: the old value is applied, and the new value takes effect next cycle.

## Test plan
- Two entries (0xFF/1000 ns, 0x01/2000 ns), len 2, time +1 ns/cycle, CycleStart at t=0 → 0xFF at t=2, 0x01 at t≈1003, END_CYCLE at t≈3001 holding 0x01.
- Same list, second CycleStart at t=4000 → idx 0 reloaded, 0xFF at t=4002, `entry_change` pulses exactly once per load.
- Overrun: entry interval 10000 ns, CycleStart again at t=5000 → entry 0 reapplied at t=5002, ExitTime = 15000.
- cfg_list_len 0, admin 0xA5, CycleStart pulses → gate_states stays 0xA5, list_active stays 0.
- Zero interval: entries 0x0F/0, 0xF0/500, len 2 → 0x0F applied for exactly 3 cycles, then 0xF0.
- Assert rst_n low while in DELAY → gate_states = admin immediately, list_active 0, entry_index 0.
